fetch_decode_queue: RTL and testbench

Elastic buffer between instruction fetch and decode in the MIPS single-cycle-to-pipelined datapath. It captures each fetched {pc, instruction} pair into a small FIFO, so decode can stall without losing fetches. It discards all buffered entries on a control-flow flush, and drains cleanly when fetch signals end of program. Decode always sees instruction and PC from the same entry, and holds `done` once the program has fully drained.

---
 rtl/mips_pkg.sv | 16 +
 rtl/fetch_decode_queue.sv | 109 ++++++++++
 tb/tb_fetch_decode_queue.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: instruction-memory geometry, the NOP
// encoding, and the fetch/decode queue state type.
package mips_pkg;

  localparam int unsigned PC_W    = 13;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } fdq_state_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// Elastic {pc, instruction} FIFO between fetch and decode with flush,
// end-of-program drain and a sticky done flag.
module fetch_decode_queue #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PC_W    = mips_pkg::PC_W,
  parameter int unsigned INSTR_W = mips_pkg::INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  input  logic                       flush,
  input  logic                       end_program,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done
);

  import mips_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = PC_W + INSTR_W;

  // Each entry holds pc in the upper bits and the instruction below it, so
  // decode can never see fields from two different fetches.
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  fdq_state_t    state_q, state_d;

  logic push;
  logic pop;

  assign in_ready  = (count_q < CW'(DEPTH)) && (state_q == RUN);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign out_pc    = out_valid ? mem_q[head_q][EW-1 -: PC_W]   : '0;
  assign out_instr = out_valid ? mem_q[head_q][INSTR_W-1:0]    : INSTR_NOP[INSTR_W-1:0];
  assign count     = count_q;
  assign done      = (state_q == DONE);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = {in_pc, in_instr};
        tail_d        = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // DRAIN looks at the post-update occupancy so an empty or flushed queue
  // finishes on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (end_program) state_d = DRAIN;
      DRAIN:   if (count_d == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= RUN;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomised and directed bench for fetch_decode_queue against a queue-based
// behavioural model.
module tb_fetch_decode_queue;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned PC_W    = 13;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CW      = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc = '0;
  logic [INSTR_W-1:0] in_instr = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               flush = 1'b0;
  logic               end_program = 1'b0;
  logic [CW-1:0]      count;
  logic               done;

  int checks   = 0;
  int failures = 0;

  // Model: list of pending {pc, instr}; phase 0 = running, 1 = draining, 2 = finished.
  logic [PC_W+INSTR_W-1:0] mq[$];
  int                      ms = 0;

  fetch_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .flush(flush), .end_program(end_program), .count(count), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [CW+PC_W+INSTR_W+2:0] exp_vec();
    logic [PC_W-1:0]    p = '0;
    logic [INSTR_W-1:0] n = '0;
    logic [PC_W+INSTR_W-1:0] e;
    if (mq.size() != 0) begin
      e = mq[0];
      p = e[PC_W+INSTR_W-1:INSTR_W];
      n = e[INSTR_W-1:0];
    end
    return {(mq.size() < DEPTH) && (ms == 0), mq.size() != 0, ms == 2,
            CW'(mq.size()), p, n};
  endfunction

  // Advance one clock and the model by the same edge; returns at posedge+1.
  task automatic tick();
    bit p, o;
    int sz = mq.size();
    p = in_valid && (sz < DEPTH) && (ms == 0) && !flush;
    o = (sz != 0) && out_ready && !flush;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (o) void'(mq.pop_front());
      if (p) mq.push_back({in_pc, in_instr});
    end
    if (ms == 0 && end_program) ms = 1;
    else if (ms == 1 && mq.size() == 0) ms = 2;
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; flush = 0; end_program = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; #2; rst = 0;
    mq.delete(); ms = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, out_valid, done, count, out_pc, out_instr} !== {1'b1, 1'b0, 1'b0, CW'(0), PC_W'(0), 32'h0}) begin
      failures++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b done=%0b cnt=%0d pc=%0h instr=%h want 1 0 0 0 0 00000000",
               in_ready, out_valid, done, count, out_pc, out_instr);
    end
  endtask

  task automatic test_fill();
    do_reset();
    in_valid = 1; in_pc = 13'd0; in_instr = 32'h20080005; tick();
    in_pc = 13'd1; in_instr = 32'h20090003; tick();
    checks++;
    if (count !== CW'(2) || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: got cnt=%0d rdy=%0b want cnt=2 rdy=0", count, in_ready);
    end
    checks++;
    if (out_pc !== 13'd0 || out_instr !== 32'h20080005) begin
      failures++;
      $display("FAIL fill_head: got pc=%0h instr=%h want pc=0 instr=20080005", out_pc, out_instr);
    end
    in_pc = 13'd2; in_instr = 32'hDEADBEEF; tick();
    in_valid = 0;
    checks++;
    if (count !== CW'(2) || out_instr !== 32'h20080005) begin
      failures++;
      $display("FAIL fill_third_ignored: got cnt=%0d instr=%h want cnt=2 instr=20080005", count, out_instr);
    end
    out_ready = 1; tick(); tick(); out_ready = 0;
    checks++;
    if (count !== CW'(0) || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_after_pops: got cnt=%0d vld=%0b want cnt=0 vld=0", count, out_valid);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_pc = PC_W'(i); in_instr = 32'h1000_0000 + 32'(i);
      tick();
      checks++;
      if (count !== CW'(1) || out_pc !== PC_W'(i) || out_instr !== 32'h1000_0000 + 32'(i)) begin
        failures++;
        $display("FAIL stream_%0d: got cnt=%0d pc=%0d instr=%h want cnt=1 pc=%0d instr=%h",
                 i, count, out_pc, out_instr, i, 32'h1000_0000 + 32'(i));
      end
    end
    in_valid = 0; tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_empty: got vld=%0b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1;
    in_pc = 13'h100; in_instr = 32'hAAAA0001; tick();
    in_pc = 13'h101; in_instr = 32'hAAAA0002; tick();
    flush = 1; out_ready = 1; in_pc = 13'h102; in_instr = 32'hAAAA0003; tick();
    flush = 0; in_valid = 0; out_ready = 0;
    checks++;
    if (count !== CW'(0) || out_valid !== 1'b0 || out_instr !== 32'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_clear: got cnt=%0d vld=%0b instr=%h rdy=%0b want 0 0 00000000 1",
               count, out_valid, out_instr, in_ready);
    end
    in_valid = 1; in_pc = 13'h1F0; in_instr = 32'h0000BEEF; tick(); in_valid = 0;
    checks++;
    if (count !== CW'(1) || out_pc !== 13'h1F0 || out_instr !== 32'h0000BEEF) begin
      failures++;
      $display("FAIL flush_refill: got cnt=%0d pc=%0h instr=%h want 1 1f0 0000beef", count, out_pc, out_instr);
    end
  endtask

  task automatic test_drain();
    do_reset();
    in_valid = 1;
    in_pc = 13'd40; in_instr = 32'h11111111; tick();
    in_pc = 13'd41; in_instr = 32'h22222222; tick();
    in_valid = 0; end_program = 1; tick(); end_program = 0;
    checks++;
    if (in_ready !== 1'b0 || count !== CW'(2) || done !== 1'b0) begin
      failures++;
      $display("FAIL drain_enter: got rdy=%0b cnt=%0d done=%0b want 0 2 0", in_ready, count, done);
    end
    out_ready = 1; tick();
    checks++;
    if (done !== 1'b0 || out_pc !== 13'd41) begin
      failures++;
      $display("FAIL drain_pop1: got done=%0b pc=%0d want done=0 pc=41", done, out_pc);
    end
    tick();
    checks++;
    if (done !== 1'b1 || count !== CW'(0)) begin
      failures++;
      $display("FAIL drain_done: got done=%0b cnt=%0d want 1 0", done, count);
    end
    out_ready = 0; in_valid = 1; end_program = 1;
    for (int i = 0; i < 3; i++) tick();
    idle_inputs();
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0 || count !== CW'(0)) begin
      failures++;
      $display("FAIL drain_sticky: got done=%0b rdy=%0b cnt=%0d want 1 0 0", done, in_ready, count);
    end
  endtask

  task automatic test_empty_done();
    do_reset();
    end_program = 1; tick(); end_program = 0;
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL empty_drain: got done=%0b rdy=%0b want 0 0", done, in_ready);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL empty_done: got done=%0b want 1", done);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1; in_pc = 13'h55; in_instr = 32'h12345678; tick(); in_valid = 0;
    checks++;
    if (count !== CW'(1) || out_instr !== 32'h12345678) begin
      failures++;
      $display("FAIL areset_pre: got cnt=%0d instr=%h want 1 12345678", count, out_instr);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({in_ready, out_valid, count, out_pc, out_instr} !== {1'b1, 1'b0, CW'(0), PC_W'(0), 32'h0}) begin
      failures++;
      $display("FAIL areset_immediate: got rdy=%0b vld=%0b cnt=%0d pc=%0h instr=%h want 1 0 0 0 00000000",
               in_ready, out_valid, count, out_pc, out_instr);
    end
    rst = 0;
    mq.delete(); ms = 0;
  endtask

  task automatic test_random();
    logic [CW+PC_W+INSTR_W+2:0] obs, exp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid    = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 3) != 0);
      in_pc       = PC_W'($urandom);
      in_instr    = $urandom;
      flush       = ($urandom_range(0, 15) == 0);
      end_program = ($urandom_range(0, 49) == 0);
      tick();
      obs = {in_ready, out_valid, done, count, out_pc, out_instr};
      exp = exp_vec();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL random_cycle_%0d: got %h want %h (rdy,vld,done,cnt,pc,instr)", c, obs, exp);
      end
      if (ms == 2 && $urandom_range(0, 3) == 0) do_reset();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_flush();
    test_drain();
    test_empty_done();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
